router_distributor: RTL and testbench

Egress-side counterpart of the router arbiter. The arbiter merges NUM ports into one stream. This block takes one stream from a single first-word-fall-through FIFO and delivers each packet to one destination port, or to all ports for broadcast. It decodes the destination from the packet header, holds the packet until every target port has accepted it, and honours per-port full back-pressure.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_distributor_sva.sv | 49 ++++
 rtl/router_distributor.sv | 101 ++++++++++
 tb/tb_router_distributor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router arbiter/distributor pair: header layout, destination type, FSM states.
package router_pkg;

    localparam int NUM_DEF     = 4;
    localparam int PCKG_SZ_DEF = 40;
    localparam int ID_W_DEF    = $clog2(NUM_DEF);

    typedef logic [ID_W_DEF-1:0] dest_t;

    typedef enum logic {IDLE, SEND} state_t;

    // The destination field occupies the top ID_W bits of the packet.
    function automatic int dest_msb(input int pckg_sz);
        return pckg_sz - 1;
    endfunction

    // The broadcast flag sits directly below the destination field.
    function automatic int bcast_bit(input int pckg_sz, input int id_w);
        return pckg_sz - id_w - 1;
    endfunction

endpackage

// File: rtl/router_distributor_sva.sv
// Protocol checker for router_distributor: back-pressure, pop legality, hold stability, push uniqueness.
module router_distributor_sva
    import router_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int PCKG_SZ = 40
) (
    input logic               clk,
    input logic               reset,
    input logic               pndng,
    input logic               pop,
    input logic [NUM-1:0]     full,
    input logic [NUM-1:0]     push,
    input logic [PCKG_SZ-1:0] data_in,
    input logic               busy,
    input logic               done
);
    localparam int ID_W = $clog2(NUM);
    localparam int BB   = bcast_bit(PCKG_SZ, ID_W);

    // Ports already served for the packet currently held.
    logic [NUM-1:0] pushed_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pushed_q <= '0;
        end else if (pop) begin
            pushed_q <= '0;
        end else begin
            pushed_q <= pushed_q | push;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        (push & full) == '0);

    a_pop_pndng: assert property (@(posedge clk) disable iff (!reset)
        pop |-> pndng);

    a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
        (busy && !done) |=> $stable(data_in));

    a_push_once: assert property (@(posedge clk) disable iff (!reset)
        (push & pushed_q) == '0);

    a_unicast_onehot0: assert property (@(posedge clk) disable iff (!reset)
        (busy && !data_in[BB]) |-> $onehot0(push));

endmodule

// File: rtl/router_distributor.sv
// Egress distributor: pops packets from a fall-through FIFO and delivers each to one or all ports.
module router_distributor
    import router_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int PCKG_SZ = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng_i,
    input  logic [PCKG_SZ-1:0] data_out_i,
    output logic               pop_o,
    input  logic [NUM-1:0]     full_i,
    output logic [NUM-1:0]     push_o,
    output logic [PCKG_SZ-1:0] data_in_o,
    output logic               busy_o,
    output logic [15:0]        bcast_cnt_o
);
    localparam int ID_W = $clog2(NUM);
    localparam int DM   = dest_msb(PCKG_SZ);
    localparam int BB   = bcast_bit(PCKG_SZ, ID_W);

    state_t             state, state_d;
    logic [PCKG_SZ-1:0] hold_q;
    logic [NUM-1:0]     need_q;
    logic [15:0]        bcast_cnt_q;

    logic [ID_W-1:0]    dest;
    logic               bcast;
    logic [NUM-1:0]     dest_onehot;
    logic [NUM-1:0]     push_ok;
    logic               done;

    assign dest        = data_out_i[DM -: ID_W];
    assign bcast       = data_out_i[BB];
    assign dest_onehot = {{(NUM-1){1'b0}}, 1'b1} << dest;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // push_ok is the unmasked push; reset only gates what leaves the block.
    always_comb begin
        state_d = state;
        push_ok = '0;
        done    = 1'b0;
        if (state == SEND) begin
            push_ok = need_q & ~full_i;
            done    = (need_q & ~push_ok) == '0;
        end
        pop_o  = reset && pndng_i && (state == IDLE || done);
        push_o = reset ? push_ok : '0;
        case (state)
            IDLE:    if (pop_o) state_d = SEND;
            SEND:    if (done && !pndng_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q      <= '0;
            need_q      <= '0;
            bcast_cnt_q <= '0;
        end else begin
            if (pop_o) begin
                hold_q <= data_out_i;
                need_q <= bcast ? '1 : dest_onehot;
            end else if (state == SEND) begin
                need_q <= done ? '0 : (need_q & ~push_ok);
            end
            if (done && hold_q[BB]) begin
                bcast_cnt_q <= bcast_cnt_q + 16'd1;
            end
        end
    end

    assign data_in_o   = hold_q;
    assign busy_o      = (state == SEND);
    assign bcast_cnt_o = bcast_cnt_q;

    router_distributor_sva #(
        .NUM     (NUM),
        .PCKG_SZ (PCKG_SZ)
    ) u_sva (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng_i),
        .pop     (pop_o),
        .full    (full_i),
        .push    (push_o),
        .data_in (data_in_o),
        .busy    (busy_o),
        .done    (done)
    );

endmodule

// File: tb/tb_router_distributor.sv
// Directed bench for router_distributor (NUM=4, PCKG_SZ=40) with hand-computed expectations.
module tb_router_distributor;

    logic        clk = 1'b0;
    logic        reset;
    logic        pndng_i;
    logic [39:0] data_out_i;
    logic        pop_o;
    logic [3:0]  full_i;
    logic [3:0]  push_o;
    logic [39:0] data_in_o;
    logic        busy_o;
    logic [15:0] bcast_cnt_o;

    int checks = 0;
    int errors = 0;

    router_distributor #(.NUM(4), .PCKG_SZ(40)) dut (
        .clk         (clk),
        .reset       (reset),
        .pndng_i     (pndng_i),
        .data_out_i  (data_out_i),
        .pop_o       (pop_o),
        .full_i      (full_i),
        .push_o      (push_o),
        .data_in_o   (data_in_o),
        .busy_o      (busy_o),
        .bcast_cnt_o (bcast_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [1:0] d, input logic b, input logic [36:0] pl);
        return {d, b, pl};
    endfunction

    logic [39:0] pkt;
    logic [39:0] pkt2;
    int          bad_push;

    initial begin
        // Reset state, with a packet pending to prove pop is gated.
        reset = 1'b0; pndng_i = 1'b1; data_out_i = 40'h80_1234_5678; full_i = 4'b0000;
        tick(); tick();
        chk("rst_pop", pop_o, 0);
        chk("rst_push", push_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", data_in_o, 0);
        chk("rst_cnt", bcast_cnt_o, 0);
        reset = 1'b1; pndng_i = 1'b0;
        tick();

        // 1: single unicast to port 2.
        pndng_i = 1'b1; data_out_i = 40'h80_1234_5678;
        #1;
        chk("t1_pop", pop_o, 1);
        chk("t1_push0", push_o, 4'b0000);
        tick();
        pndng_i = 1'b0;
        #1;
        chk("t1_push", push_o, 4'b0100);
        chk("t1_data", data_in_o, 40'h80_1234_5678);
        chk("t1_busy", busy_o, 1);
        chk("t1_nopop", pop_o, 0);
        tick();
        chk("t1_idle", busy_o, 0);
        chk("t1_push_after", push_o, 4'b0000);

        // 2: four back-to-back unicasts to ports 0..3.
        pndng_i = 1'b1; data_out_i = mk(2'd0, 1'b0, 37'h100);
        #1;
        chk("t2_pop0", pop_o, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            data_out_i = mk(i[1:0], 1'b0, 37'h100 + 37'(i));
            #1;
            chk("t2_push", push_o, 4'b0001 << (i - 1));
            chk("t2_pop", pop_o, 1);
            chk("t2_data", data_in_o, mk(2'(i - 1), 1'b0, 37'h100 + 37'(i - 1)));
        end
        tick();
        pndng_i = 1'b0;
        #1;
        chk("t2_push3", push_o, 4'b1000);
        chk("t2_nopop", pop_o, 0);
        tick();
        chk("t2_idle", busy_o, 0);

        // 3: broadcast with ports 1 and 2 full, released three cycles later.
        pkt = mk(2'd0, 1'b1, 37'h5A5A);
        pndng_i = 1'b1; data_out_i = pkt; full_i = 4'b0110;
        #1;
        chk("t3_pop", pop_o, 1);
        tick();
        pndng_i = 1'b0;
        #1;
        chk("t3_push_a", push_o, 4'b1001);
        chk("t3_cnt0", bcast_cnt_o, 0);
        chk("t3_busy", busy_o, 1);
        tick();
        chk("t3_wait1", push_o, 4'b0000);
        tick();
        chk("t3_wait2", push_o, 4'b0000);
        chk("t3_nopop", pop_o, 0);
        tick();
        full_i = 4'b0000;
        #1;
        chk("t3_push_b", push_o, 4'b0110);
        chk("t3_data", data_in_o, pkt);
        tick();
        chk("t3_cnt1", bcast_cnt_o, 1);
        chk("t3_idle", busy_o, 0);

        // 4: unicast to port 1 held off by full while more packets wait.
        pkt  = mk(2'd1, 1'b0, 37'h0ABCDE);
        pkt2 = mk(2'd3, 1'b0, 37'h077);
        pndng_i = 1'b1; data_out_i = pkt; full_i = 4'b0010;
        #1;
        chk("t4_pop", pop_o, 1);
        tick();
        data_out_i = pkt2;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_push", push_o, 4'b0000);
            chk("t4_stall_pop", pop_o, 0);
            chk("t4_stall_data", data_in_o, pkt);
            tick();
        end
        full_i = 4'b0000;
        #1;
        chk("t4_push", push_o, 4'b0010);
        chk("t4_pop2", pop_o, 1);
        tick();
        pndng_i = 1'b0;
        #1;
        chk("t4_push2", push_o, 4'b1000);
        chk("t4_data2", data_in_o, pkt2);
        tick();
        chk("t4_idle", busy_o, 0);

        // 5: reset in the middle of a stalled broadcast.
        pkt  = mk(2'd3, 1'b1, 37'h1234);
        pkt2 = mk(2'd0, 1'b0, 37'h4321);
        pndng_i = 1'b1; data_out_i = pkt; full_i = 4'b1111;
        #1;
        chk("t5_pop", pop_o, 1);
        tick();
        data_out_i = pkt2;
        #1;
        chk("t5_stall_push", push_o, 4'b0000);
        chk("t5_busy", busy_o, 1);
        tick();
        reset = 1'b0; full_i = 4'b0000;
        #1;
        chk("t5_rst_push", push_o, 4'b0000);
        chk("t5_rst_pop", pop_o, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_busy0", busy_o, 0);
        chk("t5_cnt0", bcast_cnt_o, 0);
        chk("t5_push0", push_o, 4'b0000);
        chk("t5_pop_next", pop_o, 1);
        tick();
        pndng_i = 1'b0;
        #1;
        chk("t5_push_next", push_o, 4'b0001);
        chk("t5_data_next", data_in_o, pkt2);
        tick();
        chk("t5_idle", busy_o, 0);

        // 6: 65536 back-to-back broadcasts wrap the counter.
        pkt = mk(2'd2, 1'b1, 37'h0BEEF);
        pndng_i = 1'b1; data_out_i = pkt; full_i = 4'b0000;
        bad_push = 0;
        tick();
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) begin
                pndng_i = 1'b0;
                #1;
                chk("t6_cnt_ffff", bcast_cnt_o, 16'hFFFF);
            end
            if (push_o !== 4'b1111 || (push_o & full_i) != 4'b0000) bad_push++;
            tick();
        end
        chk("t6_push_pattern", bad_push, 0);
        chk("t6_cnt_wrap", bcast_cnt_o, 0);
        chk("t6_idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
